// File: rtl/bridge_deadtime_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bridge_deadtime_seq_if
// Brief    : Request / gate-drive bundle between command decoder and the
//            H-bridge dead-time sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface bridge_deadtime_seq_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 req_valid;
    logic [3:0]           req_top;
    logic [3:0]           req_bot;
    logic                 req_ready;
    logic                 kill;
    logic [3:0]           gate_top;
    logic [3:0]           gate_bot;
    logic                 busy;
    logic                 rej;
    logic [CNT_WIDTH-1:0] chg_cnt;

    modport master (
        output req_valid, req_top, req_bot, kill,
        input  req_ready, gate_top, gate_bot, busy, rej, chg_cnt
    );

    modport slave (
        input  req_valid, req_top, req_bot, kill,
        output req_ready, gate_top, gate_bot, busy, rej, chg_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bridge_deadtime_seq.sv
`default_nettype none
// ============================================================================
// Module   : bridge_deadtime_seq
// Brief    : H-bridge gate pattern sequencer with shoot-through rejection,
//            all-off dead time, minimum on-time and a kill override.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_deadtime_seq #(
    parameter int DEAD_CYCLES   = 50,
    parameter int MIN_ON_CYCLES = 500,
    parameter int CNT_WIDTH     = 16
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    bridge_deadtime_seq_if.slave   bus
);

    localparam int c_timer_max = (DEAD_CYCLES > MIN_ON_CYCLES) ? DEAD_CYCLES : MIN_ON_CYCLES;
    localparam int c_timer_w   = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_DEAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_timer_w-1:0]   r_timer, w_timer_nxt;
    logic [7:0]             r_cur,   w_cur_nxt;
    logic [7:0]             r_pend,  w_pend_nxt;
    logic [7:0]             r_gate,  w_gate_nxt;
    logic                   r_rej,   w_rej_nxt;
    logic [CNT_WIDTH-1:0]   r_chg,   w_chg_nxt;

    logic [7:0]             w_req;
    logic                   w_illegal;
    logic                   w_ready;
    logic                   w_xfer;

    // Patterns are packed {top, bot} so one compare covers all eight gates.
    assign w_req     = {bus.req_top, bus.req_bot};
    assign w_illegal = |(bus.req_top & bus.req_bot);
    assign w_ready   = (r_state == ST_ON) & ~bus.kill;
    assign w_xfer    = bus.req_valid & w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_ON;
            r_timer <= '0;
            r_cur   <= '0;
            r_pend  <= '0;
            r_gate  <= '0;
            r_rej   <= 1'b0;
            r_chg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_cur   <= w_cur_nxt;
            r_pend  <= w_pend_nxt;
            r_gate  <= w_gate_nxt;
            r_rej   <= w_rej_nxt;
            r_chg   <= w_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cur_nxt   = r_cur;
        w_pend_nxt  = r_pend;
        w_rej_nxt   = 1'b0;
        w_chg_nxt   = r_chg;

        if (bus.kill) begin
            // Reload every kill cycle so the dead time is measured from kill release.
            w_state_nxt = ST_DEAD;
            w_timer_nxt = c_timer_w'(DEAD_CYCLES - 1);
            w_cur_nxt   = '0;
            w_pend_nxt  = '0;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (w_xfer) begin
                        if (w_illegal) begin
                            w_rej_nxt = 1'b1;
                        end else if (w_req != r_cur) begin
                            w_pend_nxt  = w_req;
                            w_state_nxt = ST_DEAD;
                            w_timer_nxt = c_timer_w'(DEAD_CYCLES - 1);
                            if (r_chg != {CNT_WIDTH{1'b1}}) begin
                                w_chg_nxt = r_chg + CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (r_timer == '0) begin
                        w_cur_nxt   = r_pend;
                        w_state_nxt = ST_HOLD;
                        w_timer_nxt = c_timer_w'(MIN_ON_CYCLES - 1);
                    end else begin
                        w_timer_nxt = r_timer - c_timer_w'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_timer == '0) begin
                        w_state_nxt = ST_ON;
                    end else begin
                        w_timer_nxt = r_timer - c_timer_w'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_DEAD;
                    w_timer_nxt = c_timer_w'(DEAD_CYCLES - 1);
                    w_cur_nxt   = '0;
                    w_pend_nxt  = '0;
                end
            endcase
        end

        w_gate_nxt = (w_state_nxt == ST_DEAD) ? 8'h00 : w_cur_nxt;
    end

    assign bus.req_ready = w_ready;
    assign bus.gate_top  = r_gate[7:4];
    assign bus.gate_bot  = r_gate[3:0];
    assign bus.busy      = (r_state != ST_ON);
    assign bus.rej       = r_rej;
    assign bus.chg_cnt   = r_chg;

endmodule
`default_nettype wire

// File: doc/bridge_deadtime_seq.md
# bridge_deadtime_seq

Sequences the H-bridge gate pattern (TOP1-4 / BOT1-4) between the command decoder and the output pins. It accepts a requested switch pattern over a valid/ready handshake and rejects shoot-through patterns. Every pattern change passes through an all-off dead-time interval, then a minimum on-time during which no new request is taken. A kill input (error/stop path) forces all gates off within one cycle.

## Interface
- `DEAD_CYCLES`, default 50 — all-off clocks between patterns (1 µs at 50 MHz); legal range ≥1.
- `MIN_ON_CYCLES`, default 500 — clocks a new pattern is held before the next request is accepted; legal range ≥1.
- `CNT_WIDTH`, default 16 — width of the pattern-change counter.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  pattern request present.
- `req_top`  in  4  requested TOP gates, bit i-1 = TOPi.
- `req_bot`  in  4  requested BOT gates, bit i-1 = BOTi.
- `req_ready`  out  1  request can be taken this cycle (combinational).
- `kill`  in  1  level; force all gates off, hold off while high.
- `gate_top`  out  4  registered TOP gate drive.
- `gate_bot`  out  4  registered BOT gate drive.
- `busy`  out  1  high in DEAD or HOLD.
- `rej`  out  1  one-cycle pulse: an illegal request was consumed.
- `chg_cnt`  out  CNT_WIDTH  saturating count of applied pattern changes.

## Operation
- Leg i is TOPi/BOTi. A request is illegal if `(req_top & req_bot) != 0`.
- States:
  - ON: gates = current pattern.
  - DEAD: gates = 0, counting down DEAD_CYCLES.
  - HOLD: gates = new pattern, counting down MIN_ON_CYCLES.
- Reset: state ON, current = 0, pending = 0, counters 0. All outputs 0 except `req_ready` = 1.
- `req_ready` = (state == ON) & ~kill. A transfer happens when `req_valid & req_ready`.
- Outcomes of a transfer:
  - Illegal request: `rej` pulses next cycle; gates, state and count are unchanged.
  - Legal request equal to the current pattern: consumed as a no-op; no dead time, no count.
  - Legal request that differs: pending = request, state goes to DEAD with the counter loaded to DEAD_CYCLES-1, gates go to 0. `chg_cnt` increments, saturating at all-ones.
- DEAD at count 0: gates = pending, current = pending, state goes to HOLD with the counter loaded to MIN_ON_CYCLES-1.
- HOLD at count 0: state goes to ON.
- The all-zero pattern is a normal request: it still passes through DEAD and HOLD.
- Kill, in any state:
  - Next cycle gates = 0, pending = 0, current = 0, state = DEAD.
  - The DEAD counter reloads to DEAD_CYCLES-1 every cycle that kill is high.
  - Counting starts after kill falls; the block then returns through HOLD (pattern 0) to ON.
  - Kill never increments `chg_cnt`.
- A request coinciding with kill is not transferred, because ready is 0.

## Timing
- A transfer sampled at edge N gives gates = 0 for cycles N+1 … N+DEAD_CYCLES.
- The new pattern appears at N+DEAD_CYCLES+1.
- `req_ready` re-asserts at N+DEAD_CYCLES+MIN_ON_CYCLES+1.
- `busy` is high from N+1 until `req_ready` returns.
- `chg_cnt` updates at N+1. `rej` is high for exactly cycle N+1.
- Kill rising at edge K gives gates = 0 at K+1. Kill last high at edge L gives gates = 0 through L+DEAD_CYCLES and ready at L+DEAD_CYCLES+MIN_ON_CYCLES+1.
- Invariant, checked every cycle: `(gate_top & gate_bot) == 0`, and no gate bit ever goes directly 1→0→1 or 0→1 on another leg without ≥DEAD_CYCLES all-zero cycles between two differing nonzero patterns.
- `rstn` low mid-operation clears everything asynchronously; the first cycle after release is ON with gates 0.

## Test plan
- Reset, DEAD_CYCLES=4, MIN_ON_CYCLES=8: request top=0001, bot=0010 at edge 10.
  - Gates 0 on cycles 11-14; 0001/0010 from cycle 15.
  - Ready low on cycles 11-22, high at 23; `chg_cnt`=1.
- Pattern 0001/0010 active: request top=0010, bot=0001.
  - 4 all-zero cycles, then 0010/0001; `chg_cnt`=2.
  - Repeat the same request: no gate change, ready stays 1, count stays 2.
- Request top=0100, bot=0100: `rej` pulses once, gates unchanged, count unchanged, ready stays 1.
- Kill high for 3 cycles during HOLD of 0100/1000: gates 0 the next cycle; 4 zero cycles after kill falls; HOLD at 0; then ready. A request with kill high is ignored.
- Force `chg_cnt` to its max via CNT_WIDTH=2 and 5 alternating changes: count stops at 3.
- Assert `rstn` low during DEAD: gates and all status are 0 immediately; after release, ready = 1 on the first cycle.
